// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the time-multiplexed FIR filter.
//   - fir_state_t : controller states (IDLE, MAC, OUT)
//   - width_of()  : index width for a range of n values, never below 1 bit
//   - DEFAULT_CW / DEFAULT_KW : channel and tap-counter widths at the default sizes
//   - round_sat() : round-half-up right shift followed by clamping to a signed width
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_t;

    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEFAULT_N  = 16;
    localparam int DEFAULT_C  = 4;
    localparam int DEFAULT_CW = width_of(DEFAULT_C);
    localparam int DEFAULT_KW = width_of(DEFAULT_N);

    // Works on a 64-bit signed copy of the accumulator so that adding the
    // rounding bias can never overflow. The return value is already clamped
    // to the bw-bit signed range; sat reports whether clamping happened.
    function automatic logic signed [63:0] round_sat(
        input  logic signed [63:0] acc,
        input  int                 shift,
        input  int                 bw,
        output logic               sat
    );
        logic signed [63:0] biased;
        logic signed [63:0] rounded;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        biased  = (shift > 0) ? acc + (64'sd1 <<< (shift - 1)) : acc;
        rounded = biased >>> shift;
        max_v   = (64'sd1 <<< (bw - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (bw - 1));
        sat     = 1'b0;
        if (rounded > max_v) begin
            rounded = max_v;
            sat     = 1'b1;
        end else if (rounded < min_v) begin
            rounded = min_v;
            sat     = 1'b1;
        end
        return rounded;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// fir_round_sat: combinational output stage of the FIR filter.
// Shifts the accumulator right by SHIFT with round-half-up, then clamps to a
// BITWIDTH-bit signed value.
//   acc  in  ACCWIDTH  signed accumulator
//   data out BITWIDTH  signed rounded, clamped result
//   sat  out 1         result was clamped
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int ACCWIDTH = 36,
    parameter int BITWIDTH = 16,
    parameter int SHIFT    = 15
) (
    input  logic signed [ACCWIDTH-1:0] acc,
    output logic signed [BITWIDTH-1:0] data,
    output logic                       sat
);

    logic signed [63:0] acc_ext;

    // The helper already clamps, so keeping only the low BITWIDTH bits is exact.
    always_comb begin
        acc_ext = 64'(acc);
        data    = BITWIDTH'(round_sat(acc_ext, SHIFT, BITWIDTH, sat));
    end

endmodule

// File: rtl/fir_tdm.sv
// fir_tdm: time-multiplexed, multi-channel, optionally decimating FIR filter.
// A single multiply-accumulate unit is shared by N taps and C channels. Each
// channel keeps its own delay line and decimation phase.
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   coef_we/coef_addr/coef_data runtime coefficient write (accepted only while idle)
//   in_valid/in_ready           input handshake, in_chan selects the channel
//   in_chan, in_data            channel and signed sample
//   out_valid/out_ready         output handshake
//   out_chan, out_data, out_sat channel, rounded/saturated result, clip flag
module fir_tdm
    import fir_pkg::*;
#(
    parameter  int BITWIDTH  = 16,
    parameter  int COEFWIDTH = 16,
    parameter  int N         = 16,
    parameter  int C         = 4,
    parameter  int ACCWIDTH  = 36,
    parameter  int SHIFT     = 15,
    parameter  int DECIM     = 1,
    localparam int CW        = width_of(C),
    localparam int AW        = width_of(N),
    localparam int KW        = width_of(N),
    localparam int PHW       = width_of(DECIM),
    localparam int PW        = BITWIDTH + COEFWIDTH
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        coef_we,
    input  logic [AW-1:0]               coef_addr,
    input  logic signed [COEFWIDTH-1:0] coef_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CW-1:0]               in_chan,
    input  logic signed [BITWIDTH-1:0]  in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CW-1:0]               out_chan,
    output logic signed [BITWIDTH-1:0]  out_data,
    output logic                        out_sat
);

    logic signed [BITWIDTH-1:0]  z     [C][N];
    logic signed [COEFWIDTH-1:0] coef  [N];
    logic [PHW-1:0]              phase [C];

    fir_state_t                  state;
    logic [KW-1:0]               k;
    logic [CW-1:0]               ch;
    logic signed [ACCWIDTH-1:0]  acc;
    logic signed [ACCWIDTH-1:0]  acc_next;
    logic signed [PW-1:0]        prod;
    logic signed [BITWIDTH-1:0]  rs_data;
    logic                        rs_sat;
    logic                        accept;
    logic                        start;

    // Samples addressed to a channel that does not exist are consumed but
    // leave every delay line and phase untouched.
    always_comb begin
        accept = in_ready && in_valid && (int'(in_chan) < C);
        start  = accept && (phase[in_chan] == '0);
    end

    always_comb begin
        prod     = PW'(z[ch][k]) * PW'(coef[k]);
        acc_next = acc + ACCWIDTH'(prod);
    end

    // Rounding looks at acc_next so the final tap can be folded in on the same
    // edge that loads the output registers; this keeps acceptance-to-output
    // at N+1 cycles.
    fir_round_sat #(
        .ACCWIDTH (ACCWIDTH),
        .BITWIDTH (BITWIDTH),
        .SHIFT    (SHIFT)
    ) u_round_sat (
        .acc  (acc_next),
        .data (rs_data),
        .sat  (rs_sat)
    );

    // Delay lines, decimation phases and coefficients. A coefficient written in
    // the same cycle as an accept is already in place when the MAC starts.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int ci = 0; ci < C; ci++) begin
                phase[ci] <= '0;
                for (int ti = 0; ti < N; ti++) begin
                    z[ci][ti] <= '0;
                end
            end
            for (int ti = 0; ti < N; ti++) begin
                coef[ti] <= '0;
            end
        end else begin
            if (in_ready && coef_we && (int'(coef_addr) < N)) begin
                coef[coef_addr] <= coef_data;
            end
            if (accept) begin
                for (int ti = N - 1; ti > 0; ti--) begin
                    z[in_chan][ti] <= z[in_chan][ti-1];
                end
                z[in_chan][0]  <= in_data;
                phase[in_chan] <= (phase[in_chan] == PHW'(DECIM - 1)) ? '0
                                                                      : phase[in_chan] + PHW'(1);
            end
        end
    end

    // Controller. in_ready and out_valid are registered alongside the state so
    // neither depends combinationally on the handshake inputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            k         <= '0;
            ch        <= '0;
            acc       <= '0;
            out_chan  <= '0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ch       <= in_chan;
                        acc      <= '0;
                        k        <= '0;
                        state    <= MAC;
                        in_ready <= 1'b0;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    if (k == KW'(N - 1)) begin
                        k         <= '0;
                        state     <= OUT;
                        out_valid <= 1'b1;
                        out_chan  <= ch;
                        out_data  <= rs_data;
                        out_sat   <= rs_sat;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
